// File: rtl/ysyx_23060286_ifu.sv
// Instruction fetch unit: credit-limited request issue, in-order response FIFO,
// and redirect flush that discards responses still in flight for the old stream.
module ysyx_23060286_ifu #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_req_valid,
    input  logic            i_req_ready,
    output logic [XLEN-1:0] o_req_addr,
    input  logic            i_rsp_valid,
    input  logic [ILEN-1:0] i_rsp_data,
    input  logic            i_rsp_err,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [ILEN-1:0] o_inst_data,
    output logic [XLEN-1:0] o_inst_pc,
    output logic            o_inst_err,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [XLEN-1:0] r_mem_pc   [DEPTH];
    logic [ILEN-1:0] r_mem_data [DEPTH];
    logic            r_mem_err  [DEPTH];

    logic [CW:0]     w_credit_sum;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_push;
    logic            w_inst_valid;
    logic            w_pop;
    logic [CW-1:0]   w_out_next;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_credit_sum  = {1'b0, r_outstanding} + {1'b0, r_count};
    // Gated by rst so the request is not advertised while the block is held in reset.
    assign w_req_valid   = !i_rst && !i_redirect_valid && (w_credit_sum < DEPTH_W);
    assign w_req_fire    = w_req_valid && i_req_ready;
    assign w_rsp_take    = i_rsp_valid && (r_outstanding != '0);
    assign w_push        = w_rsp_take && (r_drop == '0) && !i_redirect_valid;
    assign w_inst_valid  = (r_count != '0);
    assign w_pop         = w_inst_valid && i_inst_ready;
    assign w_out_next    = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);
    assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);

    assign o_req_valid  = w_req_valid;
    assign o_req_addr   = r_fetch_pc;
    assign o_inst_valid = w_inst_valid;
    assign o_inst_data  = w_inst_valid ? r_mem_data[r_rd_ptr] : '0;
    assign o_inst_pc    = w_inst_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign o_inst_err   = w_inst_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (i_redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                // Everything still outstanding belongs to a stale stream.
                r_drop     <= w_out_next;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + STEP;
                if (w_rsp_take && (r_drop != '0))
                    r_drop <= r_drop - 1'b1;
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + STEP;
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Payload storage carries no reset; the outputs are masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
            r_mem_data[r_wr_ptr] <= i_rsp_data;
            r_mem_err[r_wr_ptr]  <= i_rsp_err;
        end
    end

    a_rsp_without_req: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_rsp_valid && (r_outstanding == '0)));
endmodule

// File: tb/tb_ysyx_23060286_ifu.sv
// Bench for the fetch unit: directed scenarios then random traffic, checked
// against an epoch-tagged memory/stream model.
module tb_ysyx_23060286_ifu;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid, rsp_err;
    logic [ILEN-1:0] rsp_data;
    logic            inst_valid, inst_ready, inst_err;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_23060286_ifu #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_addr(req_addr),
        .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data), .i_rsp_err(rsp_err),
        .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
        .o_inst_data(inst_data), .o_inst_pc(inst_pc), .o_inst_err(inst_err),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc)
    );

    typedef struct { logic [31:0] addr; int epoch; logic err; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } inst_t;

    req_t        mem_q[$];
    inst_t       exp_q[$];
    logic [31:0] m_fetch_pc;
    int          m_epoch = 0;
    logic [31:0] err_pc;
    int          err_prob;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_req_addr", 64'(req_addr), 64'(RESET_PC));
        chk("rst_inst_valid", 64'(inst_valid), 64'(0));
        chk("rst_inst_data", 64'(inst_data), 64'(0));
        chk("rst_inst_pc", 64'(inst_pc), 64'(0));
        chk("rst_inst_err", 64'(inst_err), 64'(0));
        mem_q.delete();
        exp_q.delete();
        m_fetch_pc = RESET_PC;
        m_epoch++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_req_valid", 64'(req_valid), 64'(1));
        chk("first_req_addr", 64'(req_addr), 64'(RESET_PC));
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the model.
    task automatic step(input int p_req, input int p_rsp, input int p_inst,
                        input int p_redir, input logic [31:0] rpc);
        logic  e_req_valid, e_inst_valid;
        req_t  r;
        @(negedge clk);
        req_ready      = ($urandom_range(99) < p_req);
        rsp_valid      = (mem_q.size() != 0) && ($urandom_range(99) < p_rsp);
        if (rsp_valid) begin
            rsp_data = mem_word(mem_q[0].addr);
            rsp_err  = mem_q[0].err;
        end else begin
            rsp_data = $urandom;
            rsp_err  = 1'($urandom_range(1));
        end
        inst_ready     = ($urandom_range(99) < p_inst);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = rpc;
        #1;
        e_req_valid  = (mem_q.size() + exp_q.size() < DEPTH) && !redirect_valid;
        e_inst_valid = (exp_q.size() != 0);
        chk("req_valid", 64'(req_valid), 64'(e_req_valid));
        if (e_req_valid) chk("req_addr", 64'(req_addr), 64'(m_fetch_pc));
        chk("inst_valid", 64'(inst_valid), 64'(e_inst_valid));
        if (e_inst_valid) begin
            chk("inst_pc", 64'(inst_pc), 64'(exp_q[0].pc));
            chk("inst_data", 64'(inst_data), 64'(exp_q[0].data));
            chk("inst_err", 64'(inst_err), 64'(exp_q[0].err));
        end
        if (e_inst_valid && inst_ready) void'(exp_q.pop_front());
        if (rsp_valid) begin
            r = mem_q.pop_front();
            if (r.epoch == m_epoch) exp_q.push_back('{r.addr, mem_word(r.addr), r.err});
        end
        if (e_req_valid && req_ready) begin
            mem_q.push_back('{m_fetch_pc, m_epoch,
                              (m_fetch_pc == err_pc) || ($urandom_range(99) < err_prob)});
            m_fetch_pc += 32'd4;
        end
        if (redirect_valid) begin
            exp_q.delete();
            m_epoch++;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        err_prob = 0;
        err_pc   = 32'h8000_0004;
        do_reset();

        // Streaming fetch with 1-cycle memory; second response carries a fault.
        for (int i = 0; i < 12; i++) step(100, 100, 100, 0, '0);

        // Decode stalled: credits run out with the FIFO full.
        for (int i = 0; i < 8; i++) step(100, 100, 0, 0, '0);
        chk("full_req_stall", 64'(req_valid), 64'(0));
        chk("full_inst_valid", 64'(inst_valid), 64'(1));
        step(100, 100, 100, 0, '0);
        for (int i = 0; i < 3; i++) step(100, 100, 0, 0, '0);

        // Three requests in flight, then redirect.
        for (int i = 0; i < 8; i++) step(0, 100, 100, 0, '0);
        for (int i = 0; i < 3; i++) step(100, 0, 100, 0, '0);
        step(0, 0, 100, 100, 32'h8000_0102);
        step(0, 0, 100, 0, '0);
        chk("redir_inst_valid", 64'(inst_valid), 64'(0));
        chk("redir_req_addr", 64'(req_addr), 64'h8000_0100);
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, '0);

        // Redirect coinciding with a response and a decode handshake.
        for (int i = 0; i < 3; i++) step(100, 100, 0, 0, '0);
        step(0, 100, 100, 100, 32'h8000_2000);
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, '0);

        // Back-to-back redirects while old responses are still being dropped.
        for (int i = 0; i < 3; i++) step(100, 0, 0, 0, '0);
        step(0, 100, 0, 100, 32'h8000_3000);
        step(100, 0, 0, 0, '0);
        step(0, 100, 0, 100, 32'h8000_4000);
        for (int i = 0; i < 12; i++) step(100, 100, 100, 0, '0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) step(100, 50, 0, 0, '0);
        err_pc = 32'h8000_0008;
        do_reset();
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, '0);

        // Random traffic.
        err_pc   = 32'h0000_0001;
        err_prob = 10;
        for (int i = 0; i < 3000; i++)
            step(70, 60, 70, 4, $urandom);
        for (int i = 0; i < 20; i++) step(100, 100, 100, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_23060286_ifu.md
Name: ysyx_23060286_ifu

Overview:
Parametrised instruction fetch unit for the multi-cycle successor of the single-cycle ysyx_23060286 core. It replaces the combinational PC/SNPC/PC-mux path and the directly wired instruction input. It issues fetch requests over a valid/ready memory interface and tracks up to DEPTH requests in flight. Returned instructions are buffered in an in-order FIFO and handed to decode with a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and discard stale responses.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
DEPTH, 4, FIFO entries = max outstanding + buffered; power of 2, >=2
RESET_PC, 32'h8000_0000, PC after reset (XLEN bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  output  1  fetch request valid
req_ready  input  1  memory accepts request
req_addr  output  XLEN  fetch address, word aligned
rsp_valid  input  1  response valid (always accepted, in order)
rsp_data  input  ILEN  fetched instruction
rsp_err  input  1  access fault for this response
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
inst_data  output  ILEN  instruction
inst_pc  output  XLEN  PC of inst_data
inst_err  output  1  fetch fault flag for inst_data
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch PC

Behaviour:
- State: fetch_pc, rsp_pc, outstanding counter (0..DEPTH), drop counter (0..DEPTH), FIFO of {pc, data, err}, and FIFO count. Counter width is $clog2(DEPTH)+1.
- Reset (async) sets:
  - fetch_pc = rsp_pc = RESET_PC.
  - outstanding, drop and count to 0.
  - FIFO pointers to 0.
  - All outputs: req_valid=0, inst_valid=0, req_addr=RESET_PC, inst_data/inst_pc/inst_err = 0.
- Request issue:
  - req_valid = (outstanding + count < DEPTH) && !redirect_valid; req_addr = fetch_pc.
  - Handshake (req_valid && req_ready): fetch_pc += 4 (mod 2^XLEN), outstanding++.
  - req_valid/req_addr are held stable until accepted. The only exception is redirect, which may withdraw a pending request.
- First request is presented in the first cycle after rst deasserts.
- Response handling (rsp_valid):
  - Always decrements outstanding.
  - If drop > 0: the response is discarded and drop--.
  - Otherwise push {rsp_pc, rsp_data, rsp_err} and rsp_pc += 4.
- The credit rule guarantees the FIFO never overflows. A rsp_valid with outstanding==0 is a protocol violation: ignored, with a simulation assertion.
- Output: inst_valid = count != 0; inst_* show the FIFO head. Pop on inst_valid && inst_ready.
- Latency: a response in cycle N is visible on inst_valid in cycle N+1. There is no combinational rsp→inst path.
- Same-cycle push and pop: count unchanged. Pop at count==1 with push keeps inst_valid high, showing the new entry.
- Redirect (redirect_valid in cycle N), effective at edge N+1:
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b00}. Low bits are ignored; misalignment is checked by execute.
  - FIFO flushed (count=0, so inst_valid=0 in N+1).
  - drop = outstanding after accounting for any rsp in cycle N (that response is also discarded).
  - No request is issued in cycle N. Any inst handshake in cycle N completes normally.
- Redirect while drop>0: drop is reloaded with the current outstanding count. Responses belonging to either old stream are discarded.
- rsp_err does not stop fetching; the fault is carried to decode with inst_err=1.
- Reset mid-operation: all state is cleared immediately (async). In-flight memory responses after reset are undefined; the memory is reset by the same rst.

Test Plan:
- Reset release, req_ready=1, 1-cycle response latency, inst_ready=1 → req_addr 0x80000000, 0x80000004, 0x80000008… Each inst_pc/inst_data pair matches 1 cycle after its rsp_valid.
- inst_ready=0, req_ready=1, DEPTH=4 → exactly 4 requests accepted, then req_valid=0 with count=4. Raising inst_ready frees one credit per pop and a new request follows.
- 3 outstanding, redirect_pc=0x80000100 → inst_valid=0 next cycle. The next 3 rsp_valid are dropped; the next request address is 0x80000100, and its instruction appears with inst_pc=0x80000100.
- Redirect in the same cycle as rsp_valid and inst handshake → popped instruction consumed once, the response discarded, drop equals the remaining outstanding count.
- rsp_err=1 on the 2nd response → inst_err=1 only on inst_pc=0x80000004, and fetch continues at 0x8000000C.
- Assert rst while req_valid=1 and count=2 → all outputs zero or RESET_PC immediately. After release, fetch restarts at 0x80000000.
